// File: rtl/prefetch_queue_if.sv
// Bus-master and byte-queue signal bundle for the instruction prefetch unit.
// master: the prefetch unit's view; slave: the bus controller / decoder side.
interface prefetch_queue_if #(
    parameter int QUEUE_BYTES = 16
);
    localparam int COUNT_W = $clog2(QUEUE_BYTES + 1);

    logic               o_bus_vaild;
    logic               i_bus_ready;
    logic               i_bus_busy;
    logic               o_bus_write_enable;
    logic [31:0]        o_bus_address;
    logic [31:0]        i_bus_data_read;
    logic [31:0]        o_bus_data_write;

    logic               o_queue_vaild;
    logic [7:0]         o_queue_byte;
    logic [COUNT_W-1:0] o_queue_count;
    logic               i_queue_pop;
    logic               i_flush;
    logic [31:0]        i_flush_address;

    modport master (
        output o_bus_vaild, o_bus_write_enable, o_bus_address, o_bus_data_write,
        output o_queue_vaild, o_queue_byte, o_queue_count,
        input  i_bus_ready, i_bus_busy, i_bus_data_read,
        input  i_queue_pop, i_flush, i_flush_address
    );

    modport slave (
        input  o_bus_vaild, o_bus_write_enable, o_bus_address, o_bus_data_write,
        input  o_queue_vaild, o_queue_byte, o_queue_count,
        output i_bus_ready, i_bus_busy, i_bus_data_read,
        output i_queue_pop, i_flush, i_flush_address
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch unit: issues aligned dword reads and unpacks the
// returned data little-endian into a circular byte queue drained by the decoder.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request outstanding; waiting for room (>= 4 free) and !busy
// FETCH   | read request outstanding; data is pushed into the queue on ready
// DISCARD | request orphaned by a flush; returned data is dropped on ready
module prefetch_queue #(
    parameter int          QUEUE_BYTES   = 16,
    parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
    input logic               i_clock,
    input logic               i_reset,
    prefetch_queue_if.master  bus
);
    localparam int PTR_W   = $clog2(QUEUE_BYTES);
    localparam int COUNT_W = $clog2(QUEUE_BYTES + 1);
    // A new request may start only while count <= QUEUE_BYTES - 4.
    localparam logic [COUNT_W-1:0] FILL_LIMIT = COUNT_W'(QUEUE_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               bus_vaild;
    logic [29:0]        bus_dword;

    // Fetch address is held split: dword part plus the byte offset of the
    // first useful lane (non-zero only right after a misaligned redirect).
    logic [29:0]        fetch_dword;
    logic [29:0]        fetch_dword_next;
    logic [1:0]         start_offset;
    logic [1:0]         start_offset_next;

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;

    logic [7:0]             mem     [QUEUE_BYTES];
    logic [QUEUE_BYTES-1:0] wr_en;
    logic [7:0]             wr_data [QUEUE_BYTES];
    logic [PTR_W-1:0]       slot;

    logic               push_en;
    logic               pop_en;
    logic [2:0]         push_n;
    logic               start_req;

    // State register plus the registered request valid and held bus address.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            bus_vaild <= 1'b0;
            bus_dword <= RESET_ADDRESS[31:2];
        end else begin
            state     <= state_next;
            bus_vaild <= (state_next != IDLE);
            if (start_req) begin
                bus_dword <= fetch_dword_next;
            end
        end
    end

    // Next-state logic; flush has priority over every other event.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.i_flush && !bus.i_bus_busy && (count <= FILL_LIMIT)) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (bus.i_flush) begin
                    state_next = bus.i_bus_ready ? IDLE : DISCARD;
                end else if (bus.i_bus_ready) begin
                    if ((count_next <= FILL_LIMIT) && !bus.i_bus_busy) begin
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                // The orphaned transfer completing ends the discard even if a
                // further redirect arrives in the same cycle.
                if (bus.i_bus_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath control: push/pop qualification and next-value computation.
    always_comb begin
        push_en   = (state == FETCH) && bus.i_bus_ready && !bus.i_flush;
        pop_en    = bus.i_queue_pop && (count != '0) && !bus.i_flush;
        push_n    = 3'd4 - {1'b0, start_offset};
        start_req = (state_next == FETCH) && ((state == IDLE) || push_en);

        count_next = count;
        if (bus.i_flush) begin
            count_next = '0;
        end else begin
            if (push_en) begin
                count_next = count_next + COUNT_W'(push_n);
            end
            if (pop_en) begin
                count_next = count_next - COUNT_W'(1);
            end
        end

        fetch_dword_next  = fetch_dword;
        start_offset_next = start_offset;
        if (bus.i_flush) begin
            fetch_dword_next  = bus.i_flush_address[31:2];
            start_offset_next = bus.i_flush_address[1:0];
        end else if (push_en) begin
            fetch_dword_next  = fetch_dword + 30'd1;
            start_offset_next = 2'd0;
        end
    end

    // Steer byte lanes start_offset..3 onto consecutive queue slots from tail.
    always_comb begin
        wr_en = '0;
        slot  = '0;
        for (int g = 0; g < QUEUE_BYTES; g++) begin
            wr_data[g] = 8'h00;
        end
        if (push_en) begin
            for (int j = 0; j < 4; j++) begin
                if (2'(j) >= start_offset) begin
                    slot          = tail + PTR_W'(j) - PTR_W'(start_offset);
                    wr_en[slot]   = 1'b1;
                    wr_data[slot] = bus.i_bus_data_read[8*j +: 8];
                end
            end
        end
    end

    // Queue bookkeeping and fetch address registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            fetch_dword  <= RESET_ADDRESS[31:2];
            start_offset <= RESET_ADDRESS[1:0];
            count        <= '0;
            head         <= '0;
            tail         <= '0;
        end else begin
            fetch_dword  <= fetch_dword_next;
            start_offset <= start_offset_next;
            count        <= count_next;
            if (bus.i_flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (pop_en) begin
                    head <= head + PTR_W'(1);
                end
                if (push_en) begin
                    tail <= tail + PTR_W'(push_n);
                end
            end
        end
    end

    // Byte storage, one register per slot.
    for (genvar g = 0; g < QUEUE_BYTES; g++) begin : g_slot
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                mem[g] <= 8'h00;
            end else if (wr_en[g]) begin
                mem[g] <= wr_data[g];
            end
        end
    end

    assign bus.o_bus_vaild        = bus_vaild;
    assign bus.o_bus_address      = {bus_dword, 2'b00};
    assign bus.o_bus_write_enable = 1'b0;
    assign bus.o_bus_data_write   = 32'h0000_0000;
    assign bus.o_queue_vaild      = (count != '0);
    assign bus.o_queue_byte       = mem[head];
    assign bus.o_queue_count      = count;
endmodule
